// File: rtl/mac_accumulator_pkg.sv
// Shared types and widths for the multiply-accumulate controller.
// Imported by the interface and the controller.
package mac_pkg;

  localparam int OPERAND_W = 4;
  localparam int PRODUCT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Job control, operand/result handshakes and
// multiplier hookup for mac_accumulator.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int ACC_W = 12
);

  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [OPERAND_W-1:0] in_a;
  logic [OPERAND_W-1:0] in_b;
  logic [OPERAND_W-1:0] mul_a;
  logic [OPERAND_W-1:0] mul_b;
  logic [PRODUCT_W-1:0] mul_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_sum;
  logic                 out_ovf;
  logic                 busy;

  modport slave (
    input  start,
    input  in_valid,
    input  in_a,
    input  in_b,
    input  mul_p,
    input  out_ready,
    output in_ready,
    output mul_a,
    output mul_b,
    output out_valid,
    output out_sum,
    output out_ovf,
    output busy
  );

  modport master (
    output start,
    output in_valid,
    output in_a,
    output in_b,
    output mul_p,
    output out_ready,
    input  in_ready,
    input  mul_a,
    input  mul_b,
    input  out_valid,
    input  out_sum,
    input  out_ovf,
    input  busy
  );

endinterface

// File: rtl/mac_accumulator.sv
// Accumulates N_TERMS products from an external multiplier
// into a dot-product result with a sticky wrap flag.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  localparam int PAD_W = ACC_W + 1 - PRODUCT_W;

  state_t               state_q;
  logic [OPERAND_W-1:0] mul_a_q;
  logic [OPERAND_W-1:0] mul_b_q;
  logic [ACC_W-1:0]     acc_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     take_cnt_q;
  logic [CNT_W-1:0]     add_cnt_q;
  logic                 s1_valid_q;

  logic                 in_ready;
  logic                 hs;
  logic [ACC_W:0]       sum_d;

  assign in_ready = (state_q == ACCUM) &&
                    (take_cnt_q < FULL);
  assign hs       = bus.in_valid & in_ready;

  // Extra top bit captures the carry out of the accumulator.
  assign sum_d = {1'b0, acc_q} +
                 {{PAD_W{1'b0}}, bus.mul_p};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      take_cnt_q <= '0;
      add_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          s1_valid_q <= 1'b0;
          if (bus.start) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            take_cnt_q <= '0;
            add_cnt_q  <= '0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (hs) begin
            mul_a_q    <= bus.in_a;
            mul_b_q    <= bus.in_b;
            s1_valid_q <= 1'b1;
            take_cnt_q <= take_cnt_q + 1'b1;
          end else begin
            s1_valid_q <= 1'b0;
          end
          if (s1_valid_q) begin
            acc_q     <= sum_d[ACC_W-1:0];
            add_cnt_q <= add_cnt_q + 1'b1;
            if (sum_d[ACC_W]) begin
              ovf_q <= 1'b1;
            end
            if (add_cnt_q == LAST) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          s1_valid_q <= 1'b0;
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          s1_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed job table run on a 12-bit and an 8-bit
// accumulator in lockstep, plus reset-abort sequence.
module tb_mac_accumulator;

  logic clk;
  logic rst;

  int checks;
  int errors;

  mac_accumulator_if #(.ACC_W(12)) b12 ();
  mac_accumulator_if #(.ACC_W(8))  b8 ();

  mac_accumulator #(
    .N_TERMS(4),
    .ACC_W(12)
  ) u12 (
    .clk(clk),
    .rst(rst),
    .bus(b12.slave)
  );

  mac_accumulator #(
    .N_TERMS(4),
    .ACC_W(8)
  ) u8 (
    .clk(clk),
    .rst(rst),
    .bus(b8.slave)
  );

  // External 4x4 multipliers
  assign b12.mul_p = {4'b0, b12.mul_a} * {4'b0, b12.mul_b};
  assign b8.mul_p  = {4'b0, b8.mul_a} * {4'b0, b8.mul_b};

  assign b8.start     = b12.start;
  assign b8.in_valid  = b12.in_valid;
  assign b8.in_a      = b12.in_a;
  assign b8.in_b      = b12.in_b;
  assign b8.out_ready = b12.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          gaps;
    int          glitch;
    int          hold;
    int          exp12;
    int          ovf12;
    int          exp8;
    int          ovf8;
  } job_t;

  job_t jobs[5];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, " busy12"}, int'(b12.busy), 0);
    chk({tag, " busy8"}, int'(b8.busy), 0);
    chk({tag, " in_ready"}, int'(b12.in_ready), 0);
    chk({tag, " out_valid"}, int'(b12.out_valid), 0);
  endtask

  task automatic run_job(int j);
    job_t jb;
    jb = jobs[j];
    @(negedge clk);
    b12.start = 1'b1;
    @(negedge clk);
    b12.start = 1'b0;
    chk($sformatf("j%0d busy", j), int'(b12.busy), 1);
    chk($sformatf("j%0d in_ready", j), int'(b12.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      b12.in_valid = 1'b1;
      b12.in_a     = jb.a[i*4 +: 4];
      b12.in_b     = jb.b[i*4 +: 4];
      b12.start    = (i == jb.glitch);
      @(negedge clk);
      b12.start = 1'b0;
      if (jb.gaps && i < 3) begin
        b12.in_valid = 1'b0;
        b12.in_a     = 4'hF;
        b12.in_b     = 4'hF;
        @(negedge clk);
      end
    end
    // Last handshake just happened; sum updates on the next edge.
    chk($sformatf("j%0d rdy_after_last", j), int'(b12.in_ready), 0);
    chk($sformatf("j%0d early_valid", j), int'(b12.out_valid), 0);
    b12.in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("j%0d out_valid12", j), int'(b12.out_valid), 1);
    chk($sformatf("j%0d out_valid8", j), int'(b8.out_valid), 1);
    chk($sformatf("j%0d sum12", j), int'(b12.out_sum), jb.exp12);
    chk($sformatf("j%0d ovf12", j), int'(b12.out_ovf), jb.ovf12);
    chk($sformatf("j%0d sum8", j), int'(b8.out_sum), jb.exp8);
    chk($sformatf("j%0d ovf8", j), int'(b8.out_ovf), jb.ovf8);
    for (int h = 0; h < jb.hold; h++) begin
      @(negedge clk);
      chk($sformatf("j%0d hold%0d valid", j, h),
          int'(b12.out_valid), 1);
      chk($sformatf("j%0d hold%0d sum", j, h),
          int'(b12.out_sum), jb.exp12);
      chk($sformatf("j%0d hold%0d rdy", j, h),
          int'(b12.in_ready), 0);
    end
    b12.out_ready = 1'b1;
    @(negedge clk);
    b12.out_ready = 1'b0;
    chk_idle($sformatf("j%0d after_out", j));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    b12.start     = 1'b0;
    b12.in_valid  = 1'b0;
    b12.in_a      = 4'd0;
    b12.in_b      = 4'd0;
    b12.out_ready = 1'b0;

    jobs[0] = '{16'h0F23, 16'h9F75, 1'b0, -1, 0,
                254, 0, 254, 0};
    jobs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, -1, 0,
                900, 0, 132, 1};
    jobs[2] = '{16'h1111, 16'h1111, 1'b1, -1, 5,
                4, 0, 4, 0};
    jobs[3] = '{16'h2222, 16'h2222, 1'b0, 2, 0,
                16, 0, 16, 0};
    jobs[4] = '{16'h1111, 16'hFFFF, 1'b0, -1, 0,
                60, 0, 60, 0};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset sum", int'(b12.out_sum), 0);
    chk("reset mul_a", int'(b12.mul_a), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 4; j++) begin
      run_job(j);
    end

    // Operands offered in IDLE must be ignored.
    b12.in_valid = 1'b1;
    b12.in_a     = 4'd9;
    b12.in_b     = 4'd9;
    @(negedge clk);
    chk("idle ignore mul_a", int'(b12.mul_a), 2);
    chk_idle("idle ignore");
    b12.in_valid = 1'b0;

    // Abort a job after two accepted pairs.
    b12.start = 1'b1;
    @(negedge clk);
    b12.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b12.in_valid = 1'b1;
      b12.in_a     = 4'd7;
      b12.in_b     = 4'd9;
      @(negedge clk);
    end
    b12.in_valid = 1'b0;
    chk("abort pre mul_a", int'(b12.mul_a), 7);
    #2 rst = 1'b1;
    #1;
    chk_idle("abort");
    chk("abort sum12", int'(b12.out_sum), 0);
    chk("abort sum8", int'(b8.out_sum), 0);
    chk("abort mul_a", int'(b12.mul_a), 0);
    chk("abort mul_b", int'(b12.mul_b), 0);
    chk("abort ovf", int'(b12.out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_abort");

    run_job(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
